// File: rtl/mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_pkg : shared widths, FSM encodings and alignment helpers for the     |
// |           memory-access pipeline stage.                                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 5;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_REQ   = 2'd1;
  localparam state_t ST_DONE  = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

  // Byte-offset bits that must be zero for a word access.
  localparam logic [1:0] WORD_OFS_MASK = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] ofs);
    return |(ofs & WORD_OFS_MASK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_write_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_write_buffer : one-entry posted write buffer with word-address match |
// |                    for load forwarding (used under MEM_WRITE_BUFFER_EN). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_write_buffer
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr,
  input  logic [ADDR_W-3:0] lookup_word,
  output logic              valid,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [DATA_W-1:0] buf_data,
  output logic              hit
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (clr) begin
      valid_d = 1'b0;
    end
    if (wr_en) begin
      valid_d = 1'b1;
      addr_d  = wr_addr;
      data_d  = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign valid    = valid_q;
  assign buf_addr = addr_q;
  assign buf_data = data_q;
  assign hit      = valid_q && (addr_q[ADDR_W-1:2] == lookup_word);

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_stage : MEM pipeline stage with req/ack memory port, upstream stall  |
// |             and MEM/WB register. Define MEM_WRITE_BUFFER_EN to add a     |
// |             one-entry posted write buffer.                               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              mem_to_reg_in,
  input  logic [ADDR_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [REG_W-1:0]  regd_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_stall,
  output logic              addr_err,
  output logic              wb_en,
  output logic              wb_mem_to_reg,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [DATA_W-1:0] wb_load_data,
  output logic [REG_W-1:0]  wb_regd
);

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              addr_err_q, addr_err_d;
  logic              wb_en_q, wb_en_d;
  logic              wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic [DATA_W-1:0] wb_alu_result_q, wb_alu_result_d;
  logic [DATA_W-1:0] wb_load_data_q, wb_load_data_d;
  logic [REG_W-1:0]  wb_regd_q, wb_regd_d;

  logic              w_access, w_is_store, w_misaligned, w_aligned_acc;
  logic              w_load_hit, w_posted, w_needs_port, w_stall;
  logic [ADDR_W-1:0] w_word_addr;
  logic              w_buf_valid, w_buf_hit;
  logic [ADDR_W-1:0] w_buf_addr;
  logic [DATA_W-1:0] w_buf_data;

  assign w_access      = mem_r_en_in | mem_w_en_in;
  assign w_is_store    = mem_w_en_in;
  assign w_misaligned  = w_access && is_misaligned(alu_result_in[1:0]);
  assign w_aligned_acc = w_access && !w_misaligned;
  assign w_word_addr   = {alu_result_in[ADDR_W-1:2], 2'b00};

`ifdef MEM_WRITE_BUFFER_EN
  localparam logic USE_WBUF = 1'b1;
  logic w_buf_wr, w_buf_clr;

  // Stores are posted only from IDLE into an empty buffer; a full buffer forces a drain first.
  assign w_buf_wr  = (state_q == ST_IDLE) && w_posted;
  assign w_buf_clr = (state_q == ST_DRAIN) && mem_ack;

  mem_write_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wbuf (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (w_buf_wr),
    .wr_addr     (w_word_addr),
    .wr_data     (store_data_in),
    .clr         (w_buf_clr),
    .lookup_word (alu_result_in[ADDR_W-1:2]),
    .valid       (w_buf_valid),
    .buf_addr    (w_buf_addr),
    .buf_data    (w_buf_data),
    .hit         (w_buf_hit)
  );
`else
  localparam logic USE_WBUF = 1'b0;
  assign w_buf_valid = 1'b0;
  assign w_buf_hit   = 1'b0;
  assign w_buf_addr  = '0;
  assign w_buf_data  = '0;
`endif

  assign w_load_hit   = w_aligned_acc && !w_is_store && w_buf_hit;
  assign w_posted     = USE_WBUF && w_aligned_acc && w_is_store && !w_buf_valid;
  assign w_needs_port = w_aligned_acc && !w_load_hit && !w_posted;

  always_comb begin
    state_d         = state_q;
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    rdata_d         = rdata_q;
    w_stall         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        w_stall = w_needs_port;
        if (w_buf_valid) begin
          state_d     = ST_DRAIN;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = w_buf_addr;
          mem_wdata_d = w_buf_data;
        end else if (w_needs_port) begin
          state_d     = ST_REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = w_is_store;
          mem_addr_d  = w_word_addr;
          mem_wdata_d = store_data_in;
        end
      end
      ST_REQ: begin
        w_stall = 1'b1;
        if (mem_ack) begin
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            rdata_d = mem_rdata;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        w_stall = w_needs_port;
        if (mem_ack) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    wb_en_d         = wb_en_q;
    wb_mem_to_reg_d = wb_mem_to_reg_q;
    wb_alu_result_d = wb_alu_result_q;
    wb_load_data_d  = wb_load_data_q;
    wb_regd_d       = wb_regd_q;
    addr_err_d      = 1'b0;
    if (w_stall) begin
      wb_en_d   = 1'b0;
      wb_regd_d = '0;
    end else begin
      wb_en_d         = wb_en_in && !w_misaligned;
      wb_mem_to_reg_d = mem_to_reg_in;
      wb_alu_result_d = DATA_W'(alu_result_in);
      wb_regd_d       = regd_in;
      addr_err_d      = w_misaligned && (state_q != ST_DONE);
      if (state_q == ST_DONE) begin
        wb_load_data_d = rdata_q;
      end else if (w_load_hit) begin
        wb_load_data_d = w_buf_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      rdata_q         <= '0;
      addr_err_q      <= 1'b0;
      wb_en_q         <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_alu_result_q <= '0;
      wb_load_data_q  <= '0;
      wb_regd_q       <= '0;
    end else begin
      state_q         <= state_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      rdata_q         <= rdata_d;
      addr_err_q      <= addr_err_d;
      wb_en_q         <= wb_en_d;
      wb_mem_to_reg_q <= wb_mem_to_reg_d;
      wb_alu_result_q <= wb_alu_result_d;
      wb_load_data_q  <= wb_load_data_d;
      wb_regd_q       <= wb_regd_d;
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_stall     = w_stall;
  assign addr_err      = addr_err_q;
  assign wb_en         = wb_en_q;
  assign wb_mem_to_reg = wb_mem_to_reg_q;
  assign wb_alu_result = wb_alu_result_q;
  assign wb_load_data  = wb_load_data_q;
  assign wb_regd       = wb_regd_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_stage : directed self-checking bench for mem_stage; the write     |
// |                buffer scenario runs when MEM_WRITE_BUFFER_EN is defined. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, mem_to_reg_in;
  logic [31:0] alu_result_in, store_data_in;
  logic [4:0]  regd_in;
  logic        mem_req, mem_we, mem_ack, mem_stall, addr_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        wb_en, wb_mem_to_reg;
  logic [31:0] wb_alu_result, wb_load_data;
  logic [4:0]  wb_regd;

  int pass_cnt = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk           (clk),
    .reset         (reset),
    .wb_en_in      (wb_en_in),
    .mem_r_en_in   (mem_r_en_in),
    .mem_w_en_in   (mem_w_en_in),
    .mem_to_reg_in (mem_to_reg_in),
    .alu_result_in (alu_result_in),
    .store_data_in (store_data_in),
    .regd_in       (regd_in),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .mem_stall     (mem_stall),
    .addr_err      (addr_err),
    .wb_en         (wb_en),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_alu_result (wb_alu_result),
    .wb_load_data  (wb_load_data),
    .wb_regd       (wb_regd)
  );

  // Inputs change at negedge; the DUT samples them at the following posedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_nop();
    wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0; mem_to_reg_in = 1'b0;
    alu_result_in = '0; store_data_in = '0; regd_in = '0;
  endtask

  // Runs a held access until the stall drops, acking on the ack_at-th request cycle.
  task automatic run_access(input int ack_at, input logic [31:0] rdata,
                            output int n_stall, output int n_req, output logic we,
                            output logic [31:0] addr, output logic [31:0] wdata);
    bit done = 0;
    n_stall = 0; n_req = 0; we = 1'bx; addr = 'x; wdata = 'x;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      if (!mem_stall) done = 1;
      else begin
        n_stall++;
        if (mem_req) begin
          n_req++;
          if (n_req == 1) begin we = mem_we; addr = mem_addr; wdata = mem_wdata; end
          if (n_req == ack_at) begin mem_ack = 1'b1; mem_rdata = rdata; end
        end
        step();
        mem_ack = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    set_nop();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_cnt++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req: got %0h expected 0", mem_req); else pass_cnt++;
    check_cnt++; if (mem_stall !== 1'b0) $display("FAIL rst_mem_stall: got %0h expected 0", mem_stall); else pass_cnt++;
    check_cnt++; if (addr_err !== 1'b0) $display("FAIL rst_addr_err: got %0h expected 0", addr_err); else pass_cnt++;
    check_cnt++;
    if ({wb_en, wb_mem_to_reg, wb_alu_result, wb_load_data, wb_regd, mem_addr, mem_wdata, mem_we} !== '0)
      $display("FAIL rst_regs: got wb_en=%0h alu=%0h ld=%0h rd=%0h addr=%0h expected all 0",
               wb_en, wb_alu_result, wb_load_data, wb_regd, mem_addr);
    else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_nop();
    wb_en_in = 1'b1; alu_result_in = 32'h1234; regd_in = 5'd7;
    #1;
    check_cnt++; if (mem_stall !== 1'b0) $display("FAIL nop_stall: got %0h expected 0", mem_stall); else pass_cnt++;
    step();
    check_cnt++; if (wb_alu_result !== 32'h1234) $display("FAIL nop_alu: got %0h expected 1234", wb_alu_result); else pass_cnt++;
    check_cnt++; if (wb_regd !== 5'd7) $display("FAIL nop_regd: got %0d expected 7", wb_regd); else pass_cnt++;
    check_cnt++; if (wb_en !== 1'b1) $display("FAIL nop_wb_en: got %0h expected 1", wb_en); else pass_cnt++;
    check_cnt++; if (wb_load_data !== 32'h0) $display("FAIL nop_load_data: got %0h expected 0", wb_load_data); else pass_cnt++;
    set_nop();
  endtask

  task automatic test_load();
    int ns, nr; logic we; logic [31:0] a, wd;
    wb_en_in = 1'b1; mem_r_en_in = 1'b1; mem_to_reg_in = 1'b1; alu_result_in = 32'h100; regd_in = 5'd3;
    run_access(3, 32'hDEADBEEF, ns, nr, we, a, wd);
    check_cnt++; if (ns !== 4) $display("FAIL load_stall_cycles: got %0d expected 4", ns); else pass_cnt++;
    check_cnt++; if (nr !== 3) $display("FAIL load_req_cycles: got %0d expected 3", nr); else pass_cnt++;
    check_cnt++; if (we !== 1'b0 || a !== 32'h100) $display("FAIL load_port: got we=%0h addr=%0h expected we=0 addr=100", we, a); else pass_cnt++;
    check_cnt++; if (wb_en !== 1'b0) $display("FAIL load_bubble: got wb_en=%0h expected 0", wb_en); else pass_cnt++;
    step();
    check_cnt++; if (wb_load_data !== 32'hDEADBEEF) $display("FAIL load_data: got %0h expected deadbeef", wb_load_data); else pass_cnt++;
    check_cnt++;
    if (wb_en !== 1'b1 || wb_regd !== 5'd3 || wb_mem_to_reg !== 1'b1)
      $display("FAIL load_wb: got en=%0h rd=%0d m2r=%0h expected en=1 rd=3 m2r=1", wb_en, wb_regd, wb_mem_to_reg);
    else pass_cnt++;
    set_nop();
    step();
    check_cnt++; if (wb_en !== 1'b0 || mem_req !== 1'b0) $display("FAIL load_one_shot: got en=%0h req=%0h expected 0 0", wb_en, mem_req); else pass_cnt++;
  endtask

  task automatic test_store();
    int ns, nr; logic we; logic [31:0] a, wd;
    mem_w_en_in = 1'b1; alu_result_in = 32'h204; store_data_in = 32'hCAFEF00D; regd_in = 5'd2;
    run_access(1, 32'h0, ns, nr, we, a, wd);
    check_cnt++; if (ns !== 2) $display("FAIL store_stall_cycles: got %0d expected 2", ns); else pass_cnt++;
    check_cnt++;
    if (we !== 1'b1 || a !== 32'h204 || wd !== 32'hCAFEF00D)
      $display("FAIL store_port: got we=%0h addr=%0h data=%0h expected 1 204 cafef00d", we, a, wd);
    else pass_cnt++;
    step();
    check_cnt++; if (wb_en !== 1'b0) $display("FAIL store_wb_en: got %0h expected 0", wb_en); else pass_cnt++;
    set_nop();
  endtask

  task automatic test_misaligned();
    wb_en_in = 1'b1; mem_r_en_in = 1'b1; alu_result_in = 32'h102; regd_in = 5'd9;
    #1;
    check_cnt++; if (mem_stall !== 1'b0) $display("FAIL mis_stall: got %0h expected 0", mem_stall); else pass_cnt++;
    step();
    check_cnt++;
    if (addr_err !== 1'b1 || mem_req !== 1'b0 || wb_en !== 1'b0)
      $display("FAIL mis_flags: got err=%0h req=%0h wb_en=%0h expected 1 0 0", addr_err, mem_req, wb_en);
    else pass_cnt++;
    set_nop();
    step();
    check_cnt++; if (addr_err !== 1'b0) $display("FAIL mis_pulse: got %0h expected 0", addr_err); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    wb_en_in = 1'b1; mem_r_en_in = 1'b1; mem_to_reg_in = 1'b1; alu_result_in = 32'h100; regd_in = 5'd4;
    step();
    check_cnt++; if (mem_req !== 1'b1) $display("FAIL rmid_req_before: got %0h expected 1", mem_req); else pass_cnt++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_nop();
    check_cnt++; if (mem_req !== 1'b0) $display("FAIL rmid_req_after: got %0h expected 0", mem_req); else pass_cnt++;
    step();
    mem_ack = 1'b1; mem_rdata = 32'h5A5A5A5A;
    step();
    mem_ack = 1'b0;
    check_cnt++;
    if ({wb_en, wb_mem_to_reg, wb_alu_result, wb_load_data, wb_regd} !== '0 || mem_req !== 1'b0)
      $display("FAIL rmid_wb: got en=%0h ld=%0h rd=%0d req=%0h expected all 0", wb_en, wb_load_data, wb_regd, mem_req);
    else pass_cnt++;
    // A fresh aligned load must see IDLE (stall asserted); withdrawn before the edge.
    mem_r_en_in = 1'b1; alu_result_in = 32'h200;
    #1;
    check_cnt++; if (mem_stall !== 1'b1) $display("FAIL rmid_idle: got stall=%0h expected 1", mem_stall); else pass_cnt++;
    set_nop();
    step();
  endtask

`ifdef MEM_WRITE_BUFFER_EN
  task automatic test_wbuf();
    bit done = 0, drain_seen = 0, rd_after = 0;
    logic [31:0] d_addr = 'x, d_data = 'x, r_addr = 'x;
    mem_w_en_in = 1'b1; alu_result_in = 32'h300; store_data_in = 32'h11;
    #1;
    check_cnt++; if (mem_stall !== 1'b0) $display("FAIL wb_store_stall: got %0h expected 0", mem_stall); else pass_cnt++;
    step();
    set_nop();
    wb_en_in = 1'b1; mem_r_en_in = 1'b1; mem_to_reg_in = 1'b1; alu_result_in = 32'h300; regd_in = 5'd4;
    #1;
    check_cnt++; if (mem_stall !== 1'b0 || mem_req !== 1'b0) $display("FAIL wb_hit_stall: got stall=%0h req=%0h expected 0 0", mem_stall, mem_req); else pass_cnt++;
    step();
    check_cnt++; if (wb_load_data !== 32'h11 || wb_en !== 1'b1) $display("FAIL wb_hit_data: got %0h en=%0h expected 11 1", wb_load_data, wb_en); else pass_cnt++;
    alu_result_in = 32'h304; regd_in = 5'd5;
    for (int c = 0; c < 30 && !done; c++) begin
      #1;
      if (!mem_stall) done = 1;
      else begin
        if (mem_req && mem_we) begin drain_seen = 1; d_addr = mem_addr; d_data = mem_wdata; mem_ack = 1'b1; end
        else if (mem_req) begin rd_after = drain_seen; r_addr = mem_addr; mem_ack = 1'b1; mem_rdata = 32'h55; end
        step();
        mem_ack = 1'b0;
      end
    end
    check_cnt++; if (!drain_seen || d_addr !== 32'h300 || d_data !== 32'h11) $display("FAIL wb_drain: got seen=%0d addr=%0h data=%0h expected 1 300 11", drain_seen, d_addr, d_data); else pass_cnt++;
    check_cnt++; if (!done || !rd_after || r_addr !== 32'h304) $display("FAIL wb_miss_read: got done=%0d after=%0d addr=%0h expected 1 1 304", done, rd_after, r_addr); else pass_cnt++;
    step();
    check_cnt++; if (wb_load_data !== 32'h55 || wb_regd !== 5'd5) $display("FAIL wb_miss_data: got %0h rd=%0d expected 55 5", wb_load_data, wb_regd); else pass_cnt++;
    set_nop();
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_nop();
    test_load();
`ifndef MEM_WRITE_BUFFER_EN
    test_store();
`endif
    test_misaligned();
    test_reset_mid();
`ifdef MEM_WRITE_BUFFER_EN
    test_wbuf();
`endif
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access pipeline stage that sits directly downstream of the ALU/EX stage and consumes its EX/MEM register outputs.
- Performs word loads and stores through a multi-cycle request/acknowledge memory port.
- Stalls the upstream pipeline while an access is outstanding.
- Presents the MEM/WB stage register to writeback.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data word width
REG_W, 5, register-index width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
wb_en_in  in  1  EX/MEM writeback enable
mem_r_en_in  in  1  load request
mem_w_en_in  in  1  store request
mem_to_reg_in  in  1  writeback source select, 1 = load data
alu_result_in  in  ADDR_W  ALU result; the address for loads/stores
store_data_in  in  DATA_W  store data
regd_in  in  REG_W  destination register
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write access
mem_addr  out  ADDR_W  word-aligned address
mem_wdata  out  DATA_W  write data
mem_ack  in  1  one-cycle completion strobe
mem_rdata  in  DATA_W  read data, valid with mem_ack
mem_stall  out  1  combinational; upstream holds EX/MEM while high
addr_err  out  1  one-cycle misaligned-access flag
wb_en  out  1  MEM/WB writeback enable
wb_mem_to_reg  out  1  MEM/WB source select
wb_alu_result  out  DATA_W  MEM/WB ALU result
wb_load_data  out  DATA_W  MEM/WB load data
wb_regd  out  REG_W  MEM/WB destination register

Behaviour:
- Reset (synchronous, active-high, clk): state IDLE; mem_req, mem_we, addr_err, wb_en, wb_mem_to_reg = 0; mem_addr, mem_wdata, wb_alu_result, wb_load_data, wb_regd = 0.
- Access = mem_r_en_in | mem_w_en_in. If both are high, the access is treated as a store.
- Misaligned: alu_result_in[1:0] != 0 during an access.
  - No memory request is issued.
  - addr_err pulses for 1 cycle.
  - MEM/WB loads with wb_en=0.
  - No stall.
- FSM states IDLE, REQ, DONE:
  - IDLE, no access: mem_stall=0; MEM/WB captures the inputs next edge (1-cycle latency); wb_load_data unchanged.
  - IDLE, aligned access: mem_stall=1. Next edge: mem_req<=1, mem_we<=store, mem_addr<={alu_result_in[ADDR_W-1:2],2'b00}, mem_wdata<=store_data_in; go to REQ.
  - REQ: mem_stall=1; mem_req held.
    - On mem_ack: capture mem_rdata into an internal register (loads only); mem_req<=0; go to DONE.
    - Ack may arrive the first REQ cycle, or after any number of cycles.
  - DONE: mem_stall=0. MEM/WB captures the inputs plus the captured read data; go to IDLE. Upstream advances on the same edge, so the access is not reissued.
- While mem_stall=1, MEM/WB loads a bubble (wb_en=0, wb_regd=0); other wb_* fields hold.
- mem_ack outside REQ is ignored.
- Reset mid-transaction: mem_req drops on the reset edge; a late ack is ignored.
- Inputs must remain stable while mem_stall=1; behaviour is undefined otherwise.

Optional Feature:
MEM_WRITE_BUFFER_EN: one-entry posted write buffer holding address, data and valid.
- Defined:
  - Aligned store with buffer empty: captured into the buffer, no stall, 1-cycle pass-through.
  - Buffer drains via the FSM (extra state DRAIN: mem_req/mem_we=1 until ack, then valid<=0) whenever the FSM is in IDLE and no load needs the port.
  - Store with buffer full: stalls until the drain completes.
  - Load whose word address matches the buffer: returns buffer data with no memory access, 1 cycle, no stall.
  - Load that does not match while the buffer is full: stalls; drain first, then the load.
  - Reset clears valid.
- Undefined: every store uses the base FSM.

Decomposition:
- Package mem_pkg holds:
  - state enum (IDLE, REQ, DONE, DRAIN);
  - ADDR_W/DATA_W/REG_W defaults;
  - the word-alignment mask constant.
- Sub-module mem_write_buffer (one entry, match/forward logic) is instantiated only under MEM_WRITE_BUFFER_EN.

Test Plan:
1. No memory op: alu_result_in=0x1234, wb_en_in=1, regd_in=7 -> next cycle wb_alu_result=0x1234, wb_regd=7, wb_en=1; mem_stall never high.
2. Load at 0x100, ack on the 3rd REQ cycle with mem_rdata=0xDEADBEEF -> mem_stall high 4 cycles, mem_req high 3 cycles, then wb_load_data=0xDEADBEEF, wb_en=1 for exactly one cycle.
3. Store of 0xCAFEF00D to 0x204, ack on the first REQ cycle -> mem_we=1, mem_addr=0x204, mem_wdata=0xCAFEF00D, mem_stall high 2 cycles, wb_en=0.
4. Load at 0x102 -> addr_err=1 for one cycle, mem_req stays 0, wb_en=0, no stall.
5. Reset asserted in REQ, ack arrives 2 cycles later -> mem_req=0 after the reset edge, state IDLE, ack ignored, all wb_* = 0.
6. MEM_WRITE_BUFFER_EN: store 0x11 to 0x300 followed immediately by a load of 0x300 -> neither stalls, load returns 0x11 before any memory traffic; a subsequent load of 0x304 stalls until the drain write, then a read is issued.
